// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC sequencer: imem handshake, one-deep redirect buffer, wrong-path kill.
// Optional performance counters are built only when PC_CTRL_PERF_EN is defined.
module pc_fetch_ctrl #(
  parameter int RESET_HOLD = 1,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_branch_taken,
  input  logic              ex_jump,
  input  logic              ex_jr,
  input  logic              ex_break,
  input  logic              id_stall,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  output logic              inst_req,
  output logic              pc_first_mux,
  output logic [3:0]        pc_second_sel,
  output logic              pc_en,
  output logic              if_valid,
  output logic              redirect_pending,
  output logic [PERF_W-1:0] perf_redirect_cnt,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  typedef enum logic [1:0] {S_RST, S_REQ, S_DATA, S_HOLD} state_e;

  localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              pend_v_q, pend_v_d;
  logic [3:0]        pend_sel_q, pend_sel_d;
  logic              pend_first_q, pend_first_d;
  logic              kill_q, kill_d;

  logic              redir;
  logic [3:0]        redir_sel;
  logic              redir_first;
  logic              pend_apply;

  assign redir            = ex_branch_taken | ex_jump | ex_jr | ex_break;
  assign redirect_pending = pend_v_q;

  // break > jr > jump > branch; only a taken branch routes through the first mux
  always_comb begin
    redir_sel   = 4'b0001;
    redir_first = 1'b1;
    if (ex_break) begin
      redir_sel   = 4'b1000;
      redir_first = 1'b0;
    end else if (ex_jr) begin
      redir_sel   = 4'b0100;
      redir_first = 1'b0;
    end else if (ex_jump) begin
      redir_sel   = 4'b0010;
      redir_first = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RST;
      hold_cnt_q   <= HOLD_LOAD;
      pend_v_q     <= 1'b0;
      pend_sel_q   <= 4'b0000;
      pend_first_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      pend_v_q     <= pend_v_d;
      pend_sel_q   <= pend_sel_d;
      pend_first_q <= pend_first_d;
      kill_q       <= kill_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    pend_v_d      = pend_v_q;
    pend_sel_d    = pend_sel_q;
    pend_first_d  = pend_first_q;
    kill_d        = kill_q;
    inst_req      = 1'b0;
    pc_first_mux  = 1'b0;
    pc_second_sel = 4'b0000;
    pc_en         = 1'b0;
    if_valid      = 1'b0;
    pend_apply    = 1'b0;

    case (state_q)
      S_RST: begin
        if (hold_cnt_q == '0) state_d = S_REQ;
        else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end
      S_REQ: begin
        if (pend_v_q) begin
          pc_en         = 1'b1;
          pc_second_sel = pend_sel_q;
          pc_first_mux  = pend_first_q;
          pend_apply    = 1'b1;
        end else if (!redir) begin
          inst_req = 1'b1;
          if (inst_addr_ok) begin
            pc_en         = 1'b1;
            pc_second_sel = 4'b0001;
            state_d       = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (inst_data_ok) begin
          kill_d  = 1'b0;
          state_d = S_REQ;
          if (!(kill_q || redir)) begin
            if_valid = 1'b1;
            if (id_stall) state_d = S_HOLD;
          end
        end else if (redir) begin
          // response still owed by imem; drop it when it lands
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redir) begin
          state_d = S_REQ;
        end else begin
          if_valid = 1'b1;
          if (!id_stall) state_d = S_REQ;
        end
      end
      default: state_d = S_RST;
    endcase

    if (pend_apply) begin
      pend_v_d = 1'b0;
    end else if (redir && !pend_v_q) begin
      pend_v_d     = 1'b1;
      pend_sel_d   = redir_sel;
      pend_first_d = redir_first;
    end
  end

`ifdef PC_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_redirect_q, perf_redirect_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_redirect_d = perf_redirect_q;
    perf_stall_d    = perf_stall_q;
    if (pend_apply && (perf_redirect_q != '1))
      perf_redirect_d = perf_redirect_q + 1'b1;
    if ((state_q == S_HOLD) && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_redirect_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_redirect_q <= perf_redirect_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_redirect_cnt = perf_redirect_q;
  assign perf_stall_cnt    = perf_stall_q;
`else
  assign perf_redirect_cnt = '0;
  assign perf_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed + randomized bench for pc_fetch_ctrl against a phase-level fetch model.
module tb_pc_fetch_ctrl;
  localparam int RESET_HOLD = 1;
  localparam int PERF_W     = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ex_branch_taken = 1'b0, ex_jump = 1'b0, ex_jr = 1'b0, ex_break = 1'b0;
  logic id_stall = 1'b0, inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic inst_req, pc_first_mux, pc_en, if_valid, redirect_pending;
  logic [3:0] pc_second_sel;
  logic [PERF_W-1:0] perf_redirect_cnt, perf_stall_cnt;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_HOLD(RESET_HOLD), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .ex_jr(ex_jr), .ex_break(ex_break),
    .id_stall(id_stall), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_req(inst_req), .pc_first_mux(pc_first_mux), .pc_second_sel(pc_second_sel),
    .pc_en(pc_en), .if_valid(if_valid), .redirect_pending(redirect_pending),
    .perf_redirect_cnt(perf_redirect_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // model: where the fetch is, rather than which state it is in
  bit known = 0, prev_reset = 0;
  int rst_left = 0;
  bit outstanding = 0, holding = 0, kill = 0;
  logic [4:0] pend_q[$];
  int m_perf_red = 0, m_perf_stall = 0;

  logic o_req, o_en, o_first, o_valid, o_pend;
  logic [3:0] o_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ex();
    ex_branch_taken = 1'b0; ex_jump = 1'b0; ex_jr = 1'b0; ex_break = 1'b0;
  endtask

  task automatic tick();
    logic redir, had_pend, e_req, e_en, e_first, e_valid;
    logic [3:0] e_sel;
    logic [4:0] code;
    int e_pr, e_ps;
    @(negedge clk);
    o_req = inst_req; o_en = pc_en; o_first = pc_first_mux; o_sel = pc_second_sel;
    o_valid = if_valid; o_pend = redirect_pending;
    redir = ex_branch_taken | ex_jump | ex_jr | ex_break;
    code  = ex_break ? 5'b0_1000 : ex_jr ? 5'b0_0100 : ex_jump ? 5'b0_0010 : 5'b1_0001;
    e_req = 0; e_en = 0; e_first = 0; e_valid = 0; e_sel = 4'b0000;
    had_pend = (pend_q.size() != 0);
    `ifdef PC_CTRL_PERF_EN
      e_pr = m_perf_red; e_ps = m_perf_stall;
    `else
      e_pr = 0; e_ps = 0;
    `endif
    if (reset) begin
      if (known && prev_reset) begin
        chk("rst_req", o_req, 0); chk("rst_en", o_en, 0); chk("rst_sel", o_sel, 0);
        chk("rst_valid", o_valid, 0); chk("rst_pend", o_pend, 0);
        chk("rst_perf_red", perf_redirect_cnt, 0); chk("rst_perf_stall", perf_stall_cnt, 0);
      end
      known = 1; prev_reset = 1; rst_left = RESET_HOLD;
      outstanding = 0; holding = 0; kill = 0; pend_q.delete();
      m_perf_red = 0; m_perf_stall = 0;
    end else begin
      prev_reset = 0;
      if (known) begin
        if (rst_left > 0) begin
          rst_left--;
        end else if (holding) begin
          m_perf_stall++;
          if (redir) holding = 0;
          else begin
            e_valid = 1;
            if (!id_stall) holding = 0;
          end
        end else if (outstanding) begin
          if (inst_data_ok) begin
            outstanding = 0;
            if (!(kill || redir)) begin
              e_valid = 1;
              holding = id_stall;
            end
            kill = 0;
          end else if (redir) kill = 1;
        end else if (had_pend) begin
          e_en = 1; e_sel = pend_q[0][3:0]; e_first = pend_q[0][4];
          void'(pend_q.pop_front());
          m_perf_red++;
        end else if (!redir) begin
          e_req = 1;
          if (inst_addr_ok) begin
            e_en = 1; e_sel = 4'b0001; outstanding = 1;
          end
        end
        if (redir && !had_pend) pend_q.push_back(code);
        chk("inst_req", o_req, e_req); chk("pc_en", o_en, e_en);
        chk("pc_second_sel", o_sel, e_sel); chk("pc_first_mux", o_first, e_first);
        chk("if_valid", o_valid, e_valid); chk("redirect_pending", o_pend, had_pend);
        chk("perf_redirect_cnt", perf_redirect_cnt, e_pr);
        chk("perf_stall_cnt", perf_stall_cnt, e_ps);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_req, n_valid, n_req, n_brk, n_jmp, hold_len;

    // 1: reset 3 cycles, first request timing, plain fetch
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    first_req = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (o_req && first_req == 0) first_req = i;
    end
    chk("t1_first_req_cycle", first_req, RESET_HOLD + 1);
    for (int k = 0; k < 2; k++) begin
      inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
      chk("t1_fetch_en", o_en, 1); chk("t1_fetch_sel", o_sel, 4'b0001);
      tick();
      inst_data_ok = 1'b1; tick(); inst_data_ok = 1'b0;
      chk("t1_fetch_valid", o_valid, 1);
    end

    // 2: jump while requesting
    ex_jump = 1'b1; tick(); clear_ex();
    chk("t2_req_drop", o_req, 0);
    tick();
    chk("t2_apply_en", o_en, 1); chk("t2_apply_sel", o_sel, 4'b0010);
    tick();
    chk("t2_new_req", o_req, 1);

    // 3: taken branch while the response is outstanding
    inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
    n_valid = 0;
    ex_branch_taken = 1'b1; tick(); clear_ex(); n_valid += o_valid;
    tick(); n_valid += o_valid;
    inst_data_ok = 1'b1; tick(); inst_data_ok = 1'b0; n_valid += o_valid;
    chk("t3_no_valid", n_valid, 0);
    tick();
    chk("t3_apply_en", o_en, 1); chk("t3_apply_sel", o_sel, 4'b0001);
    chk("t3_apply_first", o_first, 1);

    // 4: break+jr together, jump one cycle later
    n_brk = 0; n_jmp = 0;
    ex_break = 1'b1; ex_jr = 1'b1; tick(); clear_ex();
    ex_jump = 1'b1; tick(); clear_ex();
    n_brk += (o_en && o_sel == 4'b1000); n_jmp += (o_en && o_sel == 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_brk += (o_en && o_sel == 4'b1000); n_jmp += (o_en && o_sel == 4'b0010);
    end
    chk("t4_break_applies", n_brk, 1); chk("t4_jump_applies", n_jmp, 0);

    // 5: ID stalls for 3 cycles starting with the response
    inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
    tick();
    n_valid = 0; n_req = 0;
    inst_data_ok = 1'b1; id_stall = 1'b1; tick(); inst_data_ok = 1'b0;
    n_valid += o_valid; n_req += o_req;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) id_stall = 1'b0;
      tick();
      n_valid += o_valid; n_req += o_req;
    end
    chk("t5_valid_cycles", n_valid, 4); chk("t5_no_req", n_req, 0);
    tick();
    `ifdef PC_CTRL_PERF_EN
      chk("t5_stall_cnt", perf_stall_cnt, 3);
    `else
      chk("t5_stall_cnt", perf_stall_cnt, 0);
    `endif

    // 6: reset while a killed response and a redirect are pending
    inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
    ex_jump = 1'b1; tick(); clear_ex();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    inst_data_ok = 1'b1; tick(); inst_data_ok = 1'b0;
    chk("t6_stray_valid", o_valid, 0); chk("t6_pending", o_pend, 0);
    tick();
    chk("t6_restart_req", o_req, 1);

    // randomized traffic, including ID stalls and occasional resets
    hold_len = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold_len > 0) begin
        reset = 1'b1; hold_len--;
      end else begin
        reset = 1'b0;
        if ($urandom_range(0, 299) == 0) hold_len = $urandom_range(1, 3);
      end
      inst_addr_ok    = ($urandom_range(0, 99) < 50);
      inst_data_ok    = ($urandom_range(0, 99) < 40);
      id_stall        = ($urandom_range(0, 99) < 30);
      ex_branch_taken = ($urandom_range(0, 99) < 5);
      ex_jump         = ($urandom_range(0, 99) < 4);
      ex_jr           = ($urandom_range(0, 99) < 3);
      ex_break        = ($urandom_range(0, 99) < 2);
      tick();
    end
    reset = 1'b0; clear_ex(); inst_addr_ok = 1'b0; inst_data_ok = 1'b0; id_stall = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
